// File: rtl/knn_pkg.sv
// Shared types and default sizes for the KNN sorting controller.
// No logic here: only the FSM state type and width/depth constants.
// The empty-entry value is what an unfilled sorter slot reads back as.
package knn_pkg;

  localparam int DATA_WIDTH = 32;
  localparam int CNT_WIDTH  = 32;
  localparam int MAX_K      = 128;

  localparam logic [DATA_WIDTH-1:0] KNN_EMPTY = '1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_LOAD,
    S_FLUSH,
    S_READ,
    S_FIN
  } ksort_state_t;

endpackage

// File: rtl/ksort_ctrl.sv
// Sequencer for the k-nearest sorter: clear, stream distances in, drain the k smallest.
// Latency: start -> s_ready in 2 cycles; last load -> first m_valid in 2 cycles.
// Backpressure: s_ready only in LOAD; m_valid holds with stable data until m_ready.
module ksort_ctrl #(
  parameter int DATA_WIDTH = knn_pkg::DATA_WIDTH,
  parameter int MAX_K      = knn_pkg::MAX_K,
  parameter int CNT_WIDTH  = knn_pkg::CNT_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [CNT_WIDTH-1:0]  cfg_k,
  input  logic [CNT_WIDTH-1:0]  cfg_num,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [DATA_WIDTH-1:0] s_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [31:0]           m_name,
  output logic [DATA_WIDTH-1:0] m_value,
  output logic                  m_last,
  output logic                  sort_reset,
  output logic                  sort_valid,
  output logic [DATA_WIDTH-1:0] sort_data,
  output logic                  sort_rd,
  output logic                  sort_done,
  output logic [31:0]           sort_k,
  input  logic [31:0]           sort_name,
  input  logic [DATA_WIDTH-1:0] sort_value,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);
  import knn_pkg::*;

  localparam logic [CNT_WIDTH-1:0] MAX_K_C = CNT_WIDTH'(MAX_K);
  localparam logic [CNT_WIDTH-1:0] ONE_C   = CNT_WIDTH'(1);

  ksort_state_t         state;
  logic [CNT_WIDTH-1:0] k_r;
  logic [CNT_WIDTH-1:0] num_r;
  logic [CNT_WIDTH-1:0] n_out;
  logic [CNT_WIDTH-1:0] in_cnt;
  logic [CNT_WIDTH-1:0] out_cnt;

  logic [CNT_WIDTH-1:0] n_min;
  logic                 cmd_bad;
  logic                 load_beat;
  logic                 load_last;
  logic                 read_beat;

  // Command checks, handshakes and pass-through outputs; num_r/n_out are >= 1 when used, so "-1" never wraps.
  always_comb begin
    n_min      = (cfg_k < cfg_num) ? cfg_k : cfg_num;
    cmd_bad    = (cfg_k == '0) || (cfg_k > MAX_K_C) || (cfg_num == '0);
    load_beat  = s_valid & s_ready;
    load_last  = (in_cnt == (num_r - ONE_C));
    read_beat  = m_valid & m_ready;
    m_last     = m_valid & (out_cnt == (n_out - ONE_C));
    m_name     = sort_name;
    m_value    = sort_value;
    sort_rd    = read_beat;
    sort_reset = ~reset_n | (state == S_CLEAR);
    sort_k     = 32'(k_r);
    busy       = (state != S_IDLE);
  end

  // Control FSM with registered stream/status outputs; reset aborts any query.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= S_IDLE;
      k_r        <= '0;
      num_r      <= '0;
      n_out      <= '0;
      in_cnt     <= '0;
      out_cnt    <= '0;
      s_ready    <= 1'b0;
      m_valid    <= 1'b0;
      sort_valid <= 1'b0;
      sort_data  <= '0;
      sort_done  <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
    end else begin
      sort_valid <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            k_r   <= cfg_k;
            num_r <= cfg_num;
            n_out <= n_min;
            if (cmd_bad) begin
              err <= 1'b1;
            end else begin
              state <= S_CLEAR;
            end
          end
        end
        S_CLEAR: begin
          in_cnt  <= '0;
          s_ready <= 1'b1;
          state   <= S_LOAD;
        end
        S_LOAD: begin
          if (load_beat) begin
            sort_data  <= s_data;
            sort_valid <= 1'b1;
            in_cnt     <= in_cnt + ONE_C;
            if (load_last) begin
              s_ready <= 1'b0;
              state   <= S_FLUSH;
            end
          end
        end
        S_FLUSH: begin
          // The last registered load lands in the sorter during this cycle.
          out_cnt   <= '0;
          m_valid   <= 1'b1;
          sort_done <= 1'b1;
          state     <= S_READ;
        end
        S_READ: begin
          if (read_beat) begin
            out_cnt <= out_cnt + ONE_C;
            if (m_last) begin
              m_valid   <= 1'b0;
              sort_done <= 1'b0;
              done      <= 1'b1;
              state     <= S_FIN;
            end
          end
        end
        S_FIN: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
